// File: rtl/accum_sched_pkg.sv
// Shared definitions for the accum_sched scheduler: FSM encodings,
// default parameter values and the grant selection helper.
package accum_sched_pkg;

  localparam int DEF_W    = 32;
  localparam int DEF_NREQ = 4;
  localparam int DEF_CNTW = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Lowest asserted index at or above ptr, wrapping modulo nreq.
  // Fixed priority is obtained by passing ptr = 0. Supports up to 8
  // requesters; callers zero-extend their vectors to 8 bits.
  function automatic logic [2:0] next_grant(input logic [7:0] valid,
                                            input logic [2:0] ptr,
                                            input int         nreq);
    logic [2:0] g;
    logic       found;
    int         idx;
    g     = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = (int'(ptr) + i) % nreq;
      if (!found && (i < nreq) && valid[idx[2:0]]) begin
        g     = idx[2:0];
        found = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/accum_core.sv
// Shift-and-add accumulator: y <= first ? x : 2*y + x (mod 2^W) when en.
module accum_core
  import accum_sched_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         first,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  // Accumulator register; the doubling drops the top bit, no saturation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      y <= '0;
    end else if (en) begin
      y <= first ? x : ({y[W-2:0], 1'b0} + x);
    end else begin
      y <= y;
    end
  end

endmodule

// File: rtl/accum_sched.sv
// Job scheduler for the shift-and-add accumulator. Grants one requester
// at a time, runs accum_core for len iterations (len = 0 runs once) and
// presents the tagged result on a valid/ready response port.
// Build option: ACCUM_SCHED_RR_EN selects round-robin arbitration;
// without it, the lowest asserted requester always wins.
module accum_sched
  import accum_sched_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int NREQ = DEF_NREQ,
  parameter int CNTW = DEF_CNTW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*W-1:0]        req_x,
  input  logic [NREQ*CNTW-1:0]     req_len,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [W-1:0]             resp_y,
  output logic                     busy
);

  localparam int IDW = $clog2(NREQ);

  state_t            state_r;
  state_t            state_s;
  logic [W-1:0]      x_r;
  logic [CNTW-1:0]   len_r;
  logic [CNTW-1:0]   cnt_r;
  logic [IDW-1:0]    id_r;
  logic [IDW-1:0]    grant_s;
  logic [W-1:0]      sel_x_s;
  logic [CNTW-1:0]   sel_len_s;
  logic              accept_s;
  logic              core_en_s;
  logic              core_first_s;
  logic              last_iter_s;
  logic              resp_hs_s;

`ifdef ACCUM_SCHED_RR_EN
  logic [IDW-1:0]    ptr_r;

  // Round-robin grant: search starts at the requester after the last job.
  always_comb begin
    grant_s = IDW'(next_grant(8'(req_valid), 3'(ptr_r), NREQ));
  end

  // Pointer moves past the owner of each job once its result is taken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_r <= '0;
    end else if (resp_hs_s) begin
      ptr_r <= (id_r == IDW'(NREQ - 1)) ? '0 : (id_r + IDW'(1));
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  // Fixed priority grant: lowest asserted requester.
  always_comb begin
    grant_s = IDW'(next_grant(8'(req_valid), 3'd0, NREQ));
  end
`endif

  // Operands of the currently granted requester.
  always_comb begin
    sel_x_s   = req_x[int'(grant_s)*W +: W];
    sel_len_s = req_len[int'(grant_s)*CNTW +: CNTW];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, request handshake and accumulator control.
  always_comb begin
    state_s      = state_r;
    req_ready    = '0;
    accept_s     = 1'b0;
    core_en_s    = 1'b0;
    core_first_s = 1'b0;
    resp_hs_s    = 1'b0;
    last_iter_s  = (cnt_r == (len_r - CNTW'(1)));
    case (state_r)
      ST_IDLE: begin
        // rst gates req_ready so nothing looks accepted while in reset.
        if (rst && (|req_valid)) begin
          req_ready = NREQ'(1'b1) << grant_s;
          accept_s  = 1'b1;
          state_s   = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        core_en_s    = 1'b1;
        core_first_s = (cnt_r == '0);
        if (last_iter_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        resp_hs_s = resp_ready;
        if (resp_hs_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Job registers: operands captured only at accept, counter steps in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_r   <= '0;
      len_r <= '0;
      cnt_r <= '0;
      id_r  <= '0;
    end else if (accept_s) begin
      x_r   <= sel_x_s;
      len_r <= (sel_len_s == '0) ? CNTW'(1) : sel_len_s;
      cnt_r <= '0;
      id_r  <= grant_s;
    end else if (core_en_s) begin
      cnt_r <= cnt_r + CNTW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  accum_core #(
    .W (W)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .en    (core_en_s),
    .first (core_first_s),
    .x     (x_r),
    .y     (resp_y)
  );

  // Response outputs decode straight from registers; the core holds y in DONE.
  assign resp_valid = (state_r == ST_DONE);
  assign resp_id    = id_r;
  assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_accum_sched.sv
// Self-checking bench for accum_sched. Reference model: per-requester
// job table, arbitration by the stated grant rule, and results from the
// closed form x*(2^len - 1) mod 2^W.
module tb_accum_sched;

  localparam int W    = 32;
  localparam int NREQ = 4;
  localparam int CNTW = 7;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_x = '0;
  logic [NREQ*CNTW-1:0] req_len = '0;
  logic                resp_valid;
  logic                resp_ready = 1'b0;
  logic [IDW-1:0]      resp_id;
  logic [W-1:0]        resp_y;
  logic                busy;

  int checks = 0;
  int errors = 0;

  bit              mvld [NREQ];
  logic [W-1:0]    mx   [NREQ];
  logic [CNTW-1:0] mlen [NREQ];
  int              mptr = 0;

  always #5 clk = ~clk;

  accum_sched #(.W(W), .NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_len    (req_len),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_y     (resp_y),
    .busy       (busy)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]              = mvld[i];
      req_x[i*W +: W]           = mx[i];
      req_len[i*CNTW +: CNTW]   = mlen[i];
    end
  endtask

  function automatic int model_pick();
    int idx;
    for (int off = 0; off < NREQ; off++) begin
`ifdef ACCUM_SCHED_RR_EN
      idx = (mptr + off) % NREQ;
`else
      idx = off;
`endif
      if (mvld[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] model_result(input logic [W-1:0] x, input logic [CNTW-1:0] len);
    int n;
    n = (len == '0) ? 1 : int'(len);
    if (n >= W) return 32'd0 - x;   // 2^n is 0 modulo 2^W
    return (x << n) - x;
  endfunction

  // Runs one job from the current IDLE cycle through the response handshake.
  task automatic serve(input int stall, input bit hold, input bit scramble,
                       output logic [IDW-1:0] got_id);
    int           g;
    int           el;
    logic [W-1:0] ey;
    resp_ready = 1'b0;
    drive_inputs();
    #1;
    g = model_pick();
    if (g < 0) g = 0;
    check_val("grant", 64'(req_ready), 64'd1 << g);
    check_val("idle_busy", 64'(busy), 64'd0);
    el = (mlen[g] == '0) ? 1 : int'(mlen[g]);
    ey = model_result(mx[g], mlen[g]);
    if (!hold) mvld[g] = 1'b0;
    for (int k = 0; k < el; k++) begin
      @(negedge clk);
      if (scramble) begin
        for (int i = 0; i < NREQ; i++) begin
          mx[i]   = $urandom;
          mlen[i] = CNTW'($urandom);
        end
      end
      drive_inputs();
      #1;
      check_val("run_busy", 64'(busy), 64'd1);
      check_val("run_resp_valid", 64'(resp_valid), 64'd0);
      check_val("run_req_ready", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    resp_ready = (stall == 0);
    #1;
    check_val("done_valid", 64'(resp_valid), 64'd1);
    check_val("done_y", 64'(resp_y), 64'(ey));
    check_val("done_id", 64'(resp_id), 64'(g));
    check_val("done_req_ready", 64'(req_ready), 64'd0);
    got_id = resp_id;
    for (int s = 1; s <= stall; s++) begin
      @(negedge clk);
      if (s == stall) resp_ready = 1'b1;
      #1;
      check_val("stall_valid", 64'(resp_valid), 64'd1);
      check_val("stall_y", 64'(resp_y), 64'(ey));
      check_val("stall_id", 64'(resp_id), 64'(g));
      check_val("stall_req_ready", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    check_val("post_busy", 64'(busy), 64'd0);
    check_val("post_valid", 64'(resp_valid), 64'd0);
    mptr = (g + 1) % NREQ;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '1;
    #1;
    check_val("rst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    #1;
    check_val("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_val("rst_resp_y", 64'(resp_y), 64'd0);
    check_val("rst_resp_id", 64'(resp_id), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_req_ready2", 64'(req_ready), 64'd0);
    rst  = 1'b1;
    mptr = 0;
    for (int i = 0; i < NREQ; i++) mvld[i] = 1'b0;
    drive_inputs();
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) begin
      mvld[i] = 1'b0;
      mx[i]   = '0;
      mlen[i] = '0;
    end
  endtask

  initial begin
    logic [IDW-1:0] id;
    int             exp_order [5];
    int             any;

    clear_reqs();
    do_reset();

    // Single job: x=1, len=4 -> 15
    mvld[0] = 1'b1; mx[0] = 32'd1; mlen[0] = 7'd4;
    serve(0, 1'b0, 1'b0, id);

    // Wrap-around then len = 0
    mvld[0] = 1'b1; mx[0] = 32'd1; mlen[0] = 7'd100;
    serve(0, 1'b0, 1'b0, id);
    mvld[0] = 1'b1; mx[0] = 32'd3; mlen[0] = 7'd0;
    serve(0, 1'b0, 1'b0, id);

    // Arbitration with all requesters held high
    do_reset();
`ifdef ACCUM_SCHED_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < NREQ; i++) begin
      mvld[i] = 1'b1; mx[i] = W'(i + 1); mlen[i] = 7'd2;
    end
    for (int j = 0; j < 5; j++) begin
      serve(0, 1'b1, 1'b0, id);
      check_val("arb_order", 64'(id), 64'(exp_order[j]));
    end
    clear_reqs();

    // Backpressure with other requesters waiting
    for (int i = 0; i < NREQ; i++) begin
      mvld[i] = 1'b1; mx[i] = $urandom; mlen[i] = 7'd5;
    end
    serve(10, 1'b0, 1'b0, id);
    serve(0, 1'b0, 1'b0, id);
    clear_reqs();

    // Operand changes during RUN must not affect the job
    mvld[1] = 1'b1; mx[1] = $urandom; mlen[1] = 7'd9;
    serve(0, 1'b0, 1'b1, id);
    clear_reqs();

    // Reset during iteration 3 of an 8-iteration job
    do_reset();
    mvld[0] = 1'b1; mx[0] = 32'd7; mlen[0] = 7'd1;
    serve(0, 1'b0, 1'b0, id);
    clear_reqs();
    mvld[2] = 1'b1; mx[2] = 32'd5; mlen[2] = 7'd8;
    drive_inputs();
    #1;
    check_val("midrst_grant", 64'(req_ready), 64'd4);
    mvld[2] = 1'b0;
    for (int k = 0; k < 3; k++) @(negedge clk);
    drive_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_val("midrst_busy", 64'(busy), 64'd0);
    check_val("midrst_valid", 64'(resp_valid), 64'd0);
    check_val("midrst_y", 64'(resp_y), 64'd0);
    rst  = 1'b1;
    mptr = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      #1;
      check_val("midrst_no_resp", 64'(resp_valid), 64'd0);
    end
    for (int i = 0; i < NREQ; i++) begin
      mvld[i] = 1'b1; mx[i] = $urandom; mlen[i] = CNTW'($urandom_range(0, 6));
    end
    drive_inputs();
    #1;
    check_val("midrst_ptr", 64'(req_ready), 64'd1);
    serve(0, 1'b0, 1'b0, id);

    // Randomized traffic
    for (int j = 0; j < 25; j++) begin
      any = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (!mvld[i] && ($urandom_range(0, 1) == 1)) begin
          mvld[i] = 1'b1; mx[i] = $urandom; mlen[i] = CNTW'($urandom_range(0, 40));
        end
        if (mvld[i]) any = 1;
      end
      if (any == 0) begin
        mvld[j % NREQ] = 1'b1; mx[j % NREQ] = $urandom;
        mlen[j % NREQ] = CNTW'($urandom_range(0, 40));
      end
      serve(int'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)), id);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
